// File: rtl/ped_button_request.sv
// ped_button_request
//
// Pedestrian push-button front end for the traffic-light controller. The raw
// asynchronous button is synchronised (2 flops), debounced, and rising edges of
// the debounced level are treated as presses. A press in IDLE latches a request
// that is held until the controller acknowledges the start of the pedestrian
// phase. After that, a lockout window ignores all presses and acknowledges.
//
// Optional feature (compile-time macro PED_WAIT_BLINK_EN):
//   defined   - wait_led_o blinks in PENDING with half-period BLINK_CYCLES,
//               starting high on PENDING entry.
//   undefined - wait_led_o is steady high in PENDING and no blink logic exists.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronised samples needed to accept a level change (1..65535)
//   LOCKOUT_CYCLES  - cycles after acknowledge during which presses are ignored (1..65535)
//   BLINK_CYCLES    - half-period of the wait lamp blink, optional feature only (1..65535)
//
// Ports:
//   clk_i         - system clock
//   rst_i         - asynchronous active-high reset
//   button_i      - raw pedestrian button, asynchronous, active-high
//   ack_i         - controller pulse: pedestrian phase started
//   request_o     - latched pedestrian request (high in PENDING)
//   press_pulse_o - one-cycle strobe on each accepted press
//   wait_led_o    - pedestrian "wait" lamp
//   press_count_o - saturating count of accepted presses
//   busy_o        - high while in LOCKOUT

module ped_button_request #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LOCKOUT_CYCLES  = 64,
  parameter int unsigned BLINK_CYCLES    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       button_i,
  input  logic       ack_i,
  output logic       request_o,
  output logic       press_pulse_o,
  output logic       wait_led_o,
  output logic [7:0] press_count_o,
  output logic       busy_o
);

  // Elaboration-time range checks on the configuration.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : gen_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..65535");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : gen_bad_lockout
    $error("LOCKOUT_CYCLES out of range 1..65535");
  end
  if (BLINK_CYCLES < 1 || BLINK_CYCLES > 65535) begin : gen_bad_blink
    $error("BLINK_CYCLES out of range 1..65535");
  end

  localparam logic [15:0] DebLast  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] LockLast = 16'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StPending = 2'b01,
    StLockout = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; the only place button_i is sampled.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: count consecutive samples that differ from the accepted level.
  // Any sample that agrees with the accepted level restarts the count.
  // ---------------------------------------------------------------------------
  logic        deb_q, deb_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic        press;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q >= DebLast) begin
      deb_d     = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Press is taken from the next-state level so that the FSM, the strobe and
  // the counter all update on the same edge as the debounced level rises.
  assign press = deb_d & ~deb_q;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        accept;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    accept     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StPending;
          accept  = 1'b1;
        end
      end
      StPending: begin
        // ack_i has priority: a press arriving on the same edge is simply ignored.
        if (ack_i) begin
          state_d    = StLockout;
          lock_cnt_d = LockLast;
        end
      end
      StLockout: begin
        if (lock_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          lock_cnt_d = lock_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press strobe and saturating press counter
  // ---------------------------------------------------------------------------
  logic       press_pulse_q;
  logic [7:0] press_count_q, press_count_d;

  always_comb begin
    press_count_d = press_count_q;
    if (accept && (press_count_q != 8'hFF)) begin
      press_count_d = press_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      press_pulse_q <= 1'b0;
      press_count_q <= '0;
    end else begin
      press_pulse_q <= accept;
      press_count_q <= press_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait lamp
  // ---------------------------------------------------------------------------
`ifdef PED_WAIT_BLINK_EN
  localparam logic [15:0] BlinkLast = 16'(BLINK_CYCLES - 1);

  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;

  // Phase restarts high on every state change so PENDING always opens lit.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (state_q == StPending) begin
      if (blink_cnt_q >= BlinkLast) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign wait_led_o = (state_q == StPending) & blink_q;
`else
  assign wait_led_o = (state_q == StPending);
`endif

  // ---------------------------------------------------------------------------
  // Outputs (pure decodes of registered state; all zero in reset)
  // ---------------------------------------------------------------------------
  assign request_o     = (state_q == StPending);
  assign busy_o        = (state_q == StLockout);
  assign press_pulse_o = press_pulse_q;
  assign press_count_o = press_count_q;

endmodule

// File: tb/tb_ped_button_request.sv
// Directed bench for ped_button_request with DEBOUNCE=4, LOCKOUT=10, BLINK=3.
module tb_ped_button_request;

  localparam int unsigned Deb   = 4;
  localparam int unsigned Lock  = 10;
  localparam int unsigned Blink = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       ack;
  logic       request;
  logic       press_pulse;
  logic       wait_led;
  logic [7:0] press_count;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int p0      = 0;
  int exp_led = 0;

  ped_button_request #(
    .DEBOUNCE_CYCLES(Deb),
    .LOCKOUT_CYCLES (Lock),
    .BLINK_CYCLES   (Blink)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .button_i     (button),
    .ack_i        (ack),
    .request_o    (request),
    .press_pulse_o(press_pulse),
    .wait_led_o   (wait_led),
    .press_count_o(press_count),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; observe #1 after each edge and tally strobes.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pulses += int'(press_pulse);
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    button = 1'b1;
    ack    = 1'b0;

    // Reset held with button high: everything quiet.
    step(3);
    check("rst_request", int'(request), 0);
    check("rst_pulse", int'(press_pulse), 0);
    check("rst_wait_led", int'(wait_led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(press_count), 0);

    // First accepted press lands on the 6th edge after rst falls.
    rst = 1'b0;
    p0  = pulses;
    step(5);
    check("rst_no_early_press", pulses - p0, 0);
    step(1);
    check("rst_press_edge6", int'(press_pulse), 1);
    check("rst_press_count", int'(press_count), 1);

    // Button still held through lockout into IDLE: no second press.
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("held_busy", int'(busy), 1);
    step(10);
    check("held_idle_busy", int'(busy), 0);
    check("held_no_repress_req", int'(request), 0);
    check("held_no_repress_cnt", int'(press_count), 1);
    button = 1'b0;
    step(8);

    // Fresh reset, then glitch filter: 1-cycle and 3-cycle pulses rejected.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst2_count", int'(press_count), 0);
    p0     = pulses;
    button = 1'b1;
    step(1);
    button = 1'b0;
    step(10);
    button = 1'b1;
    step(3);
    button = 1'b0;
    step(10);
    check("glitch_no_pulse", pulses - p0, 0);
    check("glitch_request", int'(request), 0);
    check("glitch_count", int'(press_count), 0);

    // Clean press held 20 cycles: single strobe after edge k+5.
    button = 1'b1;
    p0     = pulses;
    step(5);
    check("clean_no_early", pulses - p0, 0);
    step(1);
    check("clean_pulse", int'(press_pulse), 1);
    check("clean_request", int'(request), 1);
    check("clean_count", int'(press_count), 1);
    step(1);
    check("clean_single", int'(press_pulse), 0);
    check("clean_wait_led", int'(wait_led), 1);
    step(13);
    check("clean_request_held", int'(request), 1);
    check("clean_one_pulse", pulses - p0, 1);
    button = 1'b0;
    step(8);

    // Handshake: ack drops request, busy exactly 10 cycles, mid-lockout press lost.
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("hs_request_low", int'(request), 0);
    check("hs_busy_first", int'(busy), 1);
    button = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      check("hs_busy_window", int'(busy), 1);
    end
    step(1);
    check("hs_busy_end", int'(busy), 0);
    check("hs_idle_request", int'(request), 0);
    check("hs_count", int'(press_count), 1);
    check("hs_no_pulse", pulses - p0, 1);
    button = 1'b0;
    step(8);

    // Press and ack on the same edge while PENDING: ack wins.
    button = 1'b1;
    step(6);
    check("co_setup_count", int'(press_count), 2);
    button = 1'b0;
    step(8);
    p0     = pulses;
    button = 1'b1;
    step(5);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("co_request", int'(request), 0);
    check("co_busy", int'(busy), 1);
    check("co_pulse", int'(press_pulse), 0);
    check("co_count", int'(press_count), 2);
    step(10);
    check("co_no_pulse", pulses - p0, 0);
    check("co_idle_request", int'(request), 0);
    button = 1'b0;
    step(8);

    // Press maturing exactly on the last LOCKOUT edge is dropped.
    button = 1'b1;
    step(6);
    check("last_setup_count", int'(press_count), 3);
    button = 1'b0;
    step(8);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(4);
    button = 1'b1;
    p0     = pulses;
    step(6);
    check("last_busy", int'(busy), 0);
    check("last_request", int'(request), 0);
    check("last_pulse", int'(press_pulse), 0);
    check("last_count", int'(press_count), 3);
    step(8);
    check("last_no_pulse", pulses - p0, 0);
    check("last_idle_request", int'(request), 0);
    button = 1'b0;
    step(8);

    // 300 press/ack rounds: counter saturates at 255.
    p0 = pulses;
    for (int i = 0; i < 300; i++) begin
      button = 1'b1;
      step(6);
      button = 1'b0;
      ack    = 1'b1;
      step(1);
      ack = 1'b0;
      step(12);
      if (i == 250) check("sat_254", int'(press_count), 254);
      if (i == 251) check("sat_255", int'(press_count), 255);
    end
    check("sat_final", int'(press_count), 255);
    check("sat_pulses", pulses - p0, 300);

    // Reset mid-PENDING clears the request without a clock edge.
    button = 1'b1;
    step(6);
    check("arst_request_set", int'(request), 1);
    check("arst_count_hold", int'(press_count), 255);
    #2;
    rst = 1'b1;
    #1;
    check("arst_request", int'(request), 0);
    check("arst_count", int'(press_count), 0);
    check("arst_wait_led", int'(wait_led), 0);
    button = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);

    // Wait lamp pattern from PENDING entry.
    button = 1'b1;
    step(6);
    check("blink_entry_pulse", int'(press_pulse), 1);
    for (int j = 0; j < 9; j++) begin
`ifdef PED_WAIT_BLINK_EN
      exp_led = ((j / 3) % 2 == 0) ? 1 : 0;
`else
      exp_led = 1;
`endif
      check("wait_led_pattern", int'(wait_led), exp_led);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
